// File: rtl/ysyx_23060229_lsu_sram.sv
// ysyx_23060229_lsu_sram
//   Single-port word SRAM behind a valid/ready request/response handshake,
//   used as the LSU's backing store. Each access is accepted in IDLE, spends
//   LATENCY cycles in BUSY, then presents its response in RESP until consumed.
//   Storage is split into four byte-lane instances so byte and half writes
//   touch only their own lanes.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : request present           req_ready : accepting (IDLE only)
//   req_wen      : 1 = write, 0 = read       req_addr  : byte address
//   req_wdata    : lane-aligned write data   req_wmask : 01 byte / 03 half / 0f word
//   rsp_valid    : response present          rsp_ready : response consumed
//   rsp_rdata    : aligned word (reads)      rsp_err   : out-of-range or misaligned

module ysyx_23060229_lsu_sram_lane #(
    parameter int DEPTH = 4096,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    // Contents are deliberately not reset.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module ysyx_23060229_lsu_sram #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int NUM_LANES = 4;
    localparam int IW        = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    state_t state, state_nxt;
    req_t   r;
    logic [3:0] cnt;
    logic       hs;
    logic       commit;

    // Upper mask bits carry no meaning for a 32-bit memory.
    logic unused_wmask_hi;
    assign unused_wmask_hi = ^req_wmask[7:4];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign hs        = req_valid & req_ready;
    assign commit    = (state == BUSY) && (cnt == 4'd0);

    // Address decode on the captured request. BASE is word aligned, so the
    // word offset is the difference of the word-address fields.
    logic [29:0] word_off;
    logic        oor, mis, err;
    logic [7:0]  lane_wide;
    logic [3:0]  lane;

    assign word_off  = r.addr[31:2] - BASE[31:2];
    assign oor       = (r.addr < BASE) || ({2'b00, word_off} >= 32'(DEPTH));
    assign lane_wide = {4'b0000, r.mask} << r.addr[1:0];
    assign lane      = lane_wide[3:0];
    // Any mask bit pushed past lane 3 means the access straddles a word.
    assign mis       = |lane_wide[7:4];
    assign err       = oor | mis;

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hs)        state_nxt = BUSY;
            BUSY:    if (commit)    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Request capture; only a handshake can change the access in flight.
    always_ff @(posedge clk) begin
        if (hs) r <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, mask: req_wmask[3:0]};
    end

    // Latency counter and response registers.
    logic [NUM_LANES-1:0][7:0] rword;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (hs)
                cnt <= 4'(LATENCY - 1);
            else if (state == BUSY && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err || r.wen) ? 32'd0 : rword;
            end
        end
    end

    // Byte lanes. A reset on the commit edge drops the write.
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            logic we;
            assign we = commit & ~rst & r.wen & ~err & lane[i];
            ysyx_23060229_lsu_sram_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
                .clk   (clk),
                .we    (we),
                .idx   (word_off[IW-1:0]),
                .wdata (r.wdata[8*i +: 8]),
                .rdata (rword[i])
            );
        end
    endgenerate
endmodule

// File: doc/ysyx_23060229_lsu_sram.md
YSYX_23060229_LSU_SRAM -- requirements
Module: ysyx_23060229_lsu_sram

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 4096, meaning number of 32-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning BUSY cycles per access (range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  write data, lane-aligned to addr[1:0] by the initiator.
REQ-011 SHALL have port req_wmask  input  8  byte mask: 8'h01 byte, 8'h03 half, 8'h0f word; bits [7:4] ignored.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port rsp_rdata  output  32  full aligned word at addr, reads only.
REQ-015 SHALL have port rsp_err  output  1  access faulted; valid only with rsp_valid.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready.
REQ-018 SHALL, on handshake, register wen/addr/wdata/wmask, load counter with LATENCY-1, and enter BUSY.
REQ-019 SHALL, in BUSY, decrement counter each cycle and leave BUSY when it is 0 and decrementing, i.e. exactly LATENCY cycles in BUSY.
REQ-020 SHALL, on BUSY->RESP, commit the write or capture read data into rsp_rdata; rsp_valid=1 from the first RESP cycle.
REQ-021 SHALL compute index = (addr-BASE)>>2; out of range if addr<BASE or index>=DEPTH.
REQ-022 SHALL compute lane mask = wmask[3:0]<<addr[1:0]; misaligned if any shifted bit falls beyond bit 3 (half at addr[1:0]=3, word at addr[1:0]!=0).
REQ-023 SHALL set rsp_err=1 for out-of-range or misaligned; no memory update; rsp_rdata=0.
REQ-024 SHALL, on write, update only bytes whose lane-mask bit is 1; rsp_rdata=0 for writes.
REQ-025 SHALL, for reads, ignore wmask for lane selection but apply the misalignment check; sign/zero extraction is the initiator's job.
REQ-026 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1; RESP->IDLE on that edge.
REQ-027 SHALL deassert rsp_valid the cycle after rsp_valid & rsp_ready; req_ready reasserts that same cycle (minimum one idle cycle between accesses, no same-cycle accept).
REQ-028 SHALL ignore req_* inputs outside IDLE; changes during BUSY/RESP SHALL not affect the access in flight.
REQ-029 SHALL support at most one outstanding access.

Reset
REQ-030 SHALL, on rst=1 at a clock edge: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready=1 from the following cycle.
REQ-031 SHALL, on reset during BUSY, drop the access with no memory write; during RESP, discard the response.
REQ-032 SHALL NOT clear memory contents on reset.

Verification
REQ-033 SHALL cover word write 0xDEADBEEF to 0x80000010 mask 8'h0f, then read -> write response rsp_err=0 after exactly 2 BUSY cycles; read rsp_rdata=0xDEADBEEF.
REQ-034 SHALL cover byte write 0x0000AA00 to 0x80000011 mask 8'h01 over 0x11223344 -> subsequent read 0x1122AA44.
REQ-035 SHALL cover half write at 0x80000013 and read at 0x7FFFFFFC -> both rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-036 SHALL cover rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable all 5 cycles, req_ready=0 throughout, req_ready=1 the cycle after rsp_ready=1.
REQ-037 SHALL cover rst asserted in BUSY of a write 0x55555555 to 0x80000020 -> rsp_valid never asserts, later read returns prior contents.
